// File: rtl/reset_seq_ctrl.sv
// Staged reset sequencer: async assert, synchronized release, core first then CPU, plus soft reset.
// core_rst_n rises SYNC_STAGES+CORE_HOLD edges after release; cpu_rst_n CPU_DELAY+1 edges later when gated open.
module reset_seq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int CORE_HOLD   = 16,
    parameter int CPU_DELAY   = 8,
    parameter int SOFT_PULSE  = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       s_rst_n,
    input  logic       reg_cpreg_cpu_rst_n,
    input  logic       soft_rst_req,
    output logic       core_rst_n,
    output logic       cpu_rst_n,
    output logic       rst_done,
    output logic [2:0] rst_state
);

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        CORE_UP  = 3'd1,
        CPU_WAIT = 3'd2,
        RUN      = 3'd3,
        SOFT     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CORE_HOLD - 1);
    localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_DELAY - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_PULSE - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   core_rst_n_q, core_rst_n_d;
    logic                   cpu_rst_n_q, cpu_rst_n_d;
    logic                   rst_done_q, rst_done_d;
    logic                   sync_rel;

    assign sync_rel = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // The counter is cleared on every state change, so each stage counts from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            HOLD: begin
                if (sync_rel) begin
                    if (cnt_q == HOLD_LAST) state_d = CORE_UP;
                    else                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            CORE_UP: begin
                if (soft_rst_req)           state_d = SOFT;
                else if (cnt_q == CPU_LAST) state_d = CPU_WAIT;
                else                        cnt_d   = cnt_q + CNT_W'(1);
            end
            CPU_WAIT: begin
                if (soft_rst_req)             state_d = SOFT;
                else if (reg_cpreg_cpu_rst_n) state_d = RUN;
            end
            RUN: begin
                if (soft_rst_req)              state_d = SOFT;
                else if (!reg_cpreg_cpu_rst_n) state_d = CPU_WAIT;
            end
            SOFT: begin
                if (cnt_q == SOFT_LAST) state_d = HOLD;
                else                    cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = HOLD;
        endcase

        core_rst_n_d = (state_d == CORE_UP) || (state_d == CPU_WAIT) || (state_d == RUN);
        cpu_rst_n_d  = (state_d == RUN);
        rst_done_d   = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            core_rst_n_q <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
            rst_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_rst_n_q <= core_rst_n_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            rst_done_q   <= rst_done_d;
        end
    end

    assign core_rst_n = core_rst_n_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign rst_done   = rst_done_q;
    assign rst_state  = state_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl; expected values are queued as stimulus is applied.
module tb_reset_seq_ctrl;

    logic       clk = 1'b0;
    logic       s_rst_n = 1'b0;
    logic       reg_cpreg_cpu_rst_n = 1'b1;
    logic       soft_rst_req = 1'b0;
    logic       core_rst_n;
    logic       cpu_rst_n;
    logic       rst_done;
    logic [2:0] rst_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q[$];

    localparam int S_CORE = 0, S_CPU = 1, S_DONE = 2, S_STATE = 3;

    reset_seq_ctrl dut (
        .clk                 (clk),
        .s_rst_n             (s_rst_n),
        .reg_cpreg_cpu_rst_n (reg_cpreg_cpu_rst_n),
        .soft_rst_req        (soft_rst_req),
        .core_rst_n          (core_rst_n),
        .cpu_rst_n           (cpu_rst_n),
        .rst_done            (rst_done),
        .rst_state           (rst_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int get_sig(input int sel);
        case (sel)
            S_CORE:  return (core_rst_n === 1'b1) ? 1 : 0;
            S_CPU:   return (cpu_rst_n === 1'b1) ? 1 : 0;
            S_DONE:  return (rst_done === 1'b1) ? 1 : 0;
            default: return (^rst_state === 1'bx) ? -1 : int'(rst_state);
        endcase
    endfunction

    task automatic chk(input string tag, input int obs);
        int exp;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%0d expected=<empty scoreboard>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
        end
    endtask

    // Returns the absolute edge number at which the signal reached val, or -1 on timeout.
    task automatic wait_for(input int sel, input int val, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (get_sig(sel) == val) begin
                at = cyc;
                return;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        s_rst_n = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    int t0, at, bad;

    initial begin
        // Reset state
        apply_reset();
        exp_q.push_back(0); chk("reset_core", get_sig(S_CORE));
        exp_q.push_back(0); chk("reset_cpu", get_sig(S_CPU));
        exp_q.push_back(0); chk("reset_done", get_sig(S_DONE));
        exp_q.push_back(0); chk("reset_state", get_sig(S_STATE));

        // Test 1: power-on sequence
        s_rst_n = 1'b1; t0 = cyc;
        exp_q.push_back(18); wait_for(S_CORE, 1, 100, at); chk("t1_core_edge", at - t0);
        exp_q.push_back(1);  chk("t1_state_core_up", get_sig(S_STATE));
        exp_q.push_back(0);  chk("t1_cpu_low", get_sig(S_CPU));
        exp_q.push_back(26); wait_for(S_STATE, 2, 100, at); chk("t1_cpu_wait_edge", at - t0);
        exp_q.push_back(27); wait_for(S_CPU, 1, 100, at); chk("t1_cpu_edge", at - t0);
        exp_q.push_back(1);  chk("t1_done", get_sig(S_DONE));
        exp_q.push_back(3);  chk("t1_state_run", get_sig(S_STATE));

        // RUN with register gate dropping returns to CPU_WAIT next edge
        @(negedge clk); reg_cpreg_cpu_rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(2); chk("run_gate_state", get_sig(S_STATE));
        exp_q.push_back(0); chk("run_gate_cpu", get_sig(S_CPU));
        exp_q.push_back(1); chk("run_gate_core", get_sig(S_CORE));
        @(negedge clk); reg_cpreg_cpu_rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(3); chk("run_regate_state", get_sig(S_STATE));

        // Test 3: soft reset in RUN
        @(negedge clk); soft_rst_req = 1'b1; t0 = cyc;
        @(posedge clk); #1; soft_rst_req = 1'b0;
        exp_q.push_back(4); chk("t3_state_soft", get_sig(S_STATE));
        exp_q.push_back(0); chk("t3_core_low", get_sig(S_CORE));
        exp_q.push_back(0); chk("t3_cpu_low", get_sig(S_CPU));
        exp_q.push_back(0); chk("t3_done_low", get_sig(S_DONE));
        exp_q.push_back(5);  wait_for(S_STATE, 0, 100, at); chk("t3_hold_edge", at - t0);
        exp_q.push_back(21); wait_for(S_CORE, 1, 100, at); chk("t3_core_edge", at - t0);
        exp_q.push_back(30); wait_for(S_CPU, 1, 100, at); chk("t3_cpu_edge", at - t0);

        // Test 5: soft request and gate fall in the same cycle
        @(negedge clk); soft_rst_req = 1'b1; reg_cpreg_cpu_rst_n = 1'b0;
        @(posedge clk); #1; soft_rst_req = 1'b0;
        exp_q.push_back(4); chk("t5_collision_state", get_sig(S_STATE));
        reg_cpreg_cpu_rst_n = 1'b1;

        // Test 2: CPU gate held closed during bring-up
        apply_reset();
        reg_cpreg_cpu_rst_n = 1'b0;
        s_rst_n = 1'b1; t0 = cyc;
        exp_q.push_back(26); wait_for(S_STATE, 2, 100, at); chk("t2_cpu_wait_edge", at - t0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (get_sig(S_STATE) != 2 || get_sig(S_CPU) != 0 || get_sig(S_CORE) != 1) bad++;
        end
        exp_q.push_back(0); chk("t2_gate_hold_bad_cycles", bad);
        @(negedge clk); reg_cpreg_cpu_rst_n = 1'b1; t0 = cyc;
        exp_q.push_back(1); wait_for(S_CPU, 1, 20, at); chk("t2_cpu_edge", at - t0);
        exp_q.push_back(1); chk("t2_done", get_sig(S_DONE));

        // Test 4: async assertion mid-sequence in CORE_UP
        apply_reset();
        s_rst_n = 1'b1; t0 = cyc;
        exp_q.push_back(18); wait_for(S_CORE, 1, 100, at); chk("t4_core_edge_first", at - t0);
        repeat (2) @(posedge clk);
        #3 s_rst_n = 1'b0;
        #1;
        exp_q.push_back(0); chk("t4_async_core", get_sig(S_CORE));
        exp_q.push_back(0); chk("t4_async_state", get_sig(S_STATE));
        repeat (2) @(negedge clk);
        s_rst_n = 1'b1; t0 = cyc;
        exp_q.push_back(18); wait_for(S_CORE, 1, 100, at); chk("t4_core_edge_restart", at - t0);
        exp_q.push_back(27); wait_for(S_CPU, 1, 100, at); chk("t4_cpu_edge_restart", at - t0);

        // Test 6: soft request in HOLD is ignored
        apply_reset();
        s_rst_n = 1'b1; t0 = cyc;
        repeat (5) @(negedge clk);
        soft_rst_req = 1'b1;
        @(negedge clk); soft_rst_req = 1'b0;
        exp_q.push_back(18); wait_for(S_CORE, 1, 100, at); chk("t6_core_edge", at - t0);
        exp_q.push_back(27); wait_for(S_CPU, 1, 100, at); chk("t6_cpu_edge", at - t0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
